// File: rtl/hazard_ctrl_if.sv
// Control bus between the ID/EX hazard controller and the pipeline.
interface hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   // pipeline status seen by the controller
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic              ex_mem_read;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_branch_taken;
   logic              dmem_req;
   logic              dmem_ready;
   logic              cnt_clr;
   // control and performance outputs
   logic              pc_stall;
   logic              if_id_stall;
   logic              id_ex_bubble;
   logic              id_ex_stall;
   logic              ex_mem_stall;
   logic              if_id_flush;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
             ex_branch_taken, dmem_req, dmem_ready, cnt_clr,
      input  pc_stall, if_id_stall, id_ex_bubble, id_ex_stall, ex_mem_stall,
             if_id_flush, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
             ex_branch_taken, dmem_req, dmem_ready, cnt_clr,
      output pc_stall, if_id_stall, id_ex_bubble, id_ex_stall, ex_mem_stall,
             if_id_flush, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use hazard / memory-stall / branch-flush controller with saturating
// stall and flush counters. Control outputs are combinational.
module hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,   // bubbles per load-use hazard, 1..7
   parameter int CNT_W    = 16,
   parameter int ZERO_HAZ = 0    // 1: x0 takes part in hazard compare
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  hc
);

   typedef enum logic {RUN, LSTALL} state_t;

   localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

   state_t           state_q, state_d;
   logic [2:0]       bcnt_q, bcnt_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_d, stall_cnt_d, flush_cnt_q;
   logic             hz, ms;
   logic             pc_stall_o, if_id_stall_o, id_ex_bubble_o;
   logic             id_ex_stall_o, ex_mem_stall_o, if_id_flush_o;

   // hazard and memory-stall detection
   always_comb begin
      hz = hc.ex_mem_read
         & ((ZERO_HAZ != 0) | (hc.ex_rd != '0))
         & ((hc.id_use_rs1 & (hc.id_rs1 == hc.ex_rd))
          | (hc.id_use_rs2 & (hc.id_rs2 == hc.ex_rd)));
      ms = hc.dmem_req & ~hc.dmem_ready;
   end

   // state register: RUN/LSTALL plus remaining-bubble counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         bcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // next state: a memory stall freezes the machine, bubbles are not consumed
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      if (!ms) begin
         case (state_q)
            RUN: begin
               // the branch discards the ID instruction, so its hazard is moot
               if (!hc.ex_branch_taken && hz && LOAD_LAT > 1) begin
                  state_d = LSTALL;
                  bcnt_d  = LAT_M1;
               end
            end
            LSTALL: begin
               bcnt_d = bcnt_q - 3'd1;
               if (bcnt_q == 3'd1) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   // control outputs, priority reset > memory stall > branch > load-use
   always_comb begin
      pc_stall_o     = 1'b0;
      if_id_stall_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      id_ex_stall_o  = 1'b0;
      ex_mem_stall_o = 1'b0;
      if_id_flush_o  = 1'b0;
      if (rst_n) begin
         if (ms) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
         end else if (state_q == LSTALL) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
         end else if (hc.ex_branch_taken) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
         end else if (hz) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
         end
      end
   end

   // saturating counter next values; clear wins over increment
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hc.cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (pc_stall_o && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
         if (if_id_flush_o && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // performance counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hc.pc_stall     = pc_stall_o;
   assign hc.if_id_stall  = if_id_stall_o;
   assign hc.id_ex_bubble = id_ex_bubble_o;
   assign hc.id_ex_stall  = id_ex_stall_o;
   assign hc.ex_mem_stall = ex_mem_stall_o;
   assign hc.if_id_flush  = if_id_flush_o;
   assign hc.stall_cnt    = stall_cnt_q;
   assign hc.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench: three controller variants share one stimulus stream and are checked
// every cycle against a "stall cycles still owed" model.
module tb_hazard_ctrl;

   localparam int N = 3;
   localparam int LAT [N] = '{1, 3, 2};
   localparam int ZH  [N] = '{0, 0, 1};
   localparam int CW  [N] = '{16, 4, 16};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic       u1 = 0, u2 = 0, mr = 0, br = 0, dreq = 0, drdy = 0, clr = 0;

   logic [5:0]  obs  [N];   // {pc, if_id_stall, bubble, id_ex_stall, ex_mem_stall, flush}
   logic [15:0] scnt [N];
   logic [15:0] fcnt [N];

   int n_pass = 0, n_total = 0;
   int pend [N];            // stall cycles still owed to a load
   int ms_c [N];
   int mf_c [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      hazard_ctrl_if #(.REG_AW(5), .CNT_W(CW[g])) bif ();
      hazard_ctrl #(.REG_AW(5), .LOAD_LAT(LAT[g]), .CNT_W(CW[g]), .ZERO_HAZ(ZH[g]))
         dut (.clk(clk), .rst_n(rst_n), .hc(bif));
      assign bif.id_rs1          = rs1;
      assign bif.id_rs2          = rs2;
      assign bif.id_use_rs1      = u1;
      assign bif.id_use_rs2      = u2;
      assign bif.ex_mem_read     = mr;
      assign bif.ex_rd           = rd;
      assign bif.ex_branch_taken = br;
      assign bif.dmem_req        = dreq;
      assign bif.dmem_ready      = drdy;
      assign bif.cnt_clr         = clr;
      assign obs[g]  = {bif.pc_stall, bif.if_id_stall, bif.id_ex_bubble,
                        bif.id_ex_stall, bif.ex_mem_stall, bif.if_id_flush};
      assign scnt[g] = 16'(bif.stall_cnt);
      assign fcnt[g] = 16'(bif.flush_cnt);
   end

   task automatic chk(string tag, int i, logic [15:0] got, logic [15:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s dut%0d got=%0h exp=%0h", tag, i, got, exp);
   endtask

   task automatic idle();
      mr = 0; u1 = 0; u2 = 0; br = 0; dreq = 0; drdy = 0; clr = 0;
      rs1 = '0; rs2 = '0; rd = '0;
   endtask

   // check one cycle against the model, then advance model and clock
   task automatic step(string tag);
      logic [5:0] e;
      bit hz, ms;
      int mx;
      #1;
      for (int i = 0; i < N; i++) begin
         hz = mr && (ZH[i] != 0 || rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
         ms = dreq && !drdy;
         mx = (1 << CW[i]) - 1;
         if (!rst_n)        e = 6'b000000;
         else if (ms)       e = 6'b110110;
         else if (pend[i] > 0) e = 6'b111000;
         else if (br)       e = 6'b001001;
         else if (hz)       e = 6'b111000;
         else               e = 6'b000000;
         chk({tag, ".ctrl"}, i, 16'(obs[i]), 16'(e));
         chk({tag, ".scnt"}, i, scnt[i], 16'(ms_c[i]));
         chk({tag, ".fcnt"}, i, fcnt[i], 16'(mf_c[i]));
         if (!rst_n) begin
            pend[i] = 0; ms_c[i] = 0; mf_c[i] = 0;
         end else begin
            if (!ms) begin
               if (pend[i] > 0) pend[i]--;
               else if (!br && hz) pend[i] = LAT[i] - 1;
            end
            if (clr) begin
               ms_c[i] = 0; mf_c[i] = 0;
            end else begin
               if (e[5] && ms_c[i] < mx) ms_c[i]++;
               if (e[0] && mf_c[i] < mx) mf_c[i]++;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_use(int r);
      mr = 1; rd = 5'(r); rs1 = 5'(r); u1 = 1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin pend[i] = 0; ms_c[i] = 0; mf_c[i] = 0; end
      @(negedge clk);
      idle(); rst_n = 0;
      step("reset"); step("reset");
      rst_n = 1;
      step("idle");

      // single load-use hazard, EX becomes a bubble afterwards
      load_use(5); step("lu");
      idle(); repeat (4) step("lu_tail");

      // x0 destination: only the ZERO_HAZ=1 variant stalls
      load_use(0); step("x0");
      idle(); repeat (3) step("x0_tail");

      // branch and hazard together: flush wins
      load_use(5); br = 1; step("br_hz");
      idle(); repeat (3) step("br_tail");

      // memory stall during the second bubble
      load_use(7); step("ms_lu");
      idle(); dreq = 1; drdy = 0; step("ms"); step("ms");
      drdy = 1; step("ms_done");
      idle(); repeat (3) step("ms_tail");

      // branch held under memory stall flushes once ms drops
      br = 1; dreq = 1; step("br_ms");
      dreq = 0; step("br_ms_rel");
      idle(); step("br_ms_tail");

      // saturation of the 4-bit counter, then clear on a stall cycle
      idle(); clr = 1; step("clr0");
      idle(); load_use(9);
      repeat (20) step("sat");
      chk("sat_val", 1, scnt[1], 16'd15);
      clr = 1; step("clr_stall");
      clr = 0; idle(); step("after_clr");
      chk("clr_val", 1, scnt[1], 16'd0);
      repeat (3) step("clr_tail");

      // reset asserted during the second bubble
      load_use(4); step("rl");
      idle(); rst_n = 0; step("rl_rst");
      rst_n = 1; step("rl_run");
      repeat (3) step("rl_tail");

      // randomized traffic over a small register set
      for (int c = 0; c < 400; c++) begin
         rs1  = 5'($urandom_range(0, 3));
         rs2  = 5'($urandom_range(0, 3));
         rd   = 5'($urandom_range(0, 3));
         u1   = 1'($urandom_range(0, 1));
         u2   = 1'($urandom_range(0, 1));
         mr   = ($urandom_range(0, 2) == 0);
         br   = ($urandom_range(0, 5) == 0);
         dreq = ($urandom_range(0, 3) == 0);
         drdy = 1'($urandom_range(0, 1));
         clr  = ($urandom_range(0, 40) == 0);
         rst_n = ($urandom_range(0, 60) != 0);
         step("rand");
      end
      rst_n = 1; idle(); step("end");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and stall controller for the five-stage RISC-V pipeline, sitting beside the ID/EX boundary. It detects load-use hazards and inserts a configurable number of bubbles for multi-cycle load latency. It also freezes the whole pipe while the data memory is not ready, flushes IF/ID and ID/EX on a taken branch, and keeps saturating stall and flush performance counters.

## Interface
- REG_AW, 5, register-address width.
- LOAD_LAT, 1, bubbles per load-use hazard; legal range 1..7.
- CNT_W, 16, performance-counter width.
- ZERO_HAZ, 0, 0 = register 0 never creates a hazard; 1 = register 0 is compared like any other register.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads rs1 / rs2.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- dmem_req  in  1  MEM stage has an access outstanding.
- dmem_ready  in  1  data memory completes the access this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold the IF/ID register.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- id_ex_stall  out  1  hold the ID/EX register.
- ex_mem_stall  out  1  hold the EX/MEM register.
- if_id_flush  out  1  load a NOP into IF/ID.
- stall_cnt  out  CNT_W  cycles with pc_stall asserted.
- flush_cnt  out  CNT_W  cycles with if_id_flush asserted.

## Operation
**Hazard detect (combinational)**
- hz = ex_mem_read & (ZERO_HAZ | ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- ms = dmem_req & !dmem_ready.

**State machine**
- States: RUN and LSTALL. The state register plus a 3-bit bubble counter bcnt.

**Output priority, highest first, evaluated every cycle:**
1. `rst_n` = 0: all control outputs are 0.
2. ms (memory stall, any state):
   - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall = 1.
   - id_ex_bubble and if_id_flush = 0.
   - State and bcnt hold.
3. State RUN with ex_branch_taken:
   - if_id_flush and id_ex_bubble = 1; no stall.
   - hz is ignored, because the ID instruction is discarded.
   - State stays RUN.
4. State RUN with hz:
   - pc_stall, if_id_stall and id_ex_bubble = 1.
   - If LOAD_LAT = 1, the state stays RUN.
   - Otherwise the next state is LSTALL with bcnt = LOAD_LAT-1.
5. State LSTALL:
   - pc_stall, if_id_stall and id_ex_bubble = 1.
   - bcnt decrements; when bcnt = 1, the next state is RUN.
   - ex_branch_taken and hz are ignored; EX holds a bubble by construction.
6. Otherwise all control outputs are 0.

**Counters**
- stall_cnt += 1 on each cycle with pc_stall = 1; flush_cnt += 1 on each cycle with if_id_flush = 1.
- Both saturate at 2^CNT_W-1.
- cnt_clr has priority over increment: the counter reads 0 on the next cycle.

## Timing
- All control outputs are combinational from the current state and inputs. State, bcnt and the counters update on the rising clk edge.
- Reset: state = RUN, bcnt = 0, stall_cnt = 0, flush_cnt = 0. All control outputs are forced to 0 while rst_n = 0.
- Asserting reset in the middle of LSTALL or of a memory stall gives state RUN on the first cycle after rst_n returns to 1.
- Load-use stall length is exactly LOAD_LAT cycles of pc_stall, plus any ms cycles inserted, which extend it without consuming bcnt.
- A taken branch costs exactly 1 flush cycle. A taken branch held under ms flushes on the first cycle after ms drops.
- Counter increments become visible one cycle after the qualifying output cycle.

## Test plan
- **Load-use, LOAD_LAT=1:**
  - Stimulus: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1.
  - Response: exactly 1 cycle with pc_stall=if_id_stall=id_ex_bubble=1; stall_cnt=1 afterwards.
- **LOAD_LAT=3, same hazard, then EX driven with a bubble:**
  - Response: 3 consecutive stall cycles, the state returns to RUN, stall_cnt=3.
  - Repeat with ex_rd=0 and ZERO_HAZ=0: no stall.
- **Branch plus hazard in the same cycle:**
  - Stimulus: ex_branch_taken=1 and hz=1.
  - Response: if_id_flush=id_ex_bubble=1, pc_stall=0, flush_cnt=1, stall_cnt unchanged.
- **Memory stall in the middle of LSTALL (LOAD_LAT=3):**
  - Stimulus: dmem_req=1 with dmem_ready=0 for 2 cycles, starting at the second bubble.
  - Response: all four stalls asserted with id_ex_bubble=0 for those 2 cycles; bcnt held; 5 pc_stall cycles in total.
- **Saturation and clear:**
  - With CNT_W=4, 20 stall cycles give stall_cnt=15.
  - cnt_clr=1 on the same cycle as a stall gives stall_cnt=0 on the next cycle.
- **Reset in LSTALL:**
  - Stimulus: rst_n=0 for one cycle during the second bubble.
  - Response: all outputs 0 during reset; RUN with no stall afterwards when hz=0; counters 0.
